// File: rtl/stage_mem_pkg.sv
// Shared types and widths for the MEM pipeline stage.
package stage_mem_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned REG_IDX_W      = 4;
  localparam int unsigned ADDR_W_DEFAULT = 10;

  typedef struct packed {
    logic rf_we;
    logic mem_we;
    logic wb_select;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0]    rd2;
    ctrl_t                ctrl;
    logic [DATA_W-1:0]    alu_result;
    logic [REG_IDX_W-1:0] a3;
  } ex_mem_t;

  typedef struct packed {
    logic [DATA_W-1:0]    read_data;
    ctrl_t                ctrl;
    logic [DATA_W-1:0]    alu_result;
    logic [REG_IDX_W-1:0] a3;
  } mem_wb_t;

endpackage

// File: rtl/stage_mem_if.sv
// EX-side inputs and MEM/WB-side outputs of the MEM stage.
interface stage_mem_if;
  import stage_mem_pkg::*;

  logic [DATA_W-1:0]    RD2_i;
  logic                 RF_WE_i;
  logic                 MemWE_i;
  logic                 WBSelect_i;
  logic [DATA_W-1:0]    AluResult_i;
  logic [REG_IDX_W-1:0] A3_i;

  logic [DATA_W-1:0]    AluResult_mem_o;
  logic [REG_IDX_W-1:0] A3_mem_o;
  logic                 RF_WE_mem_o;

  logic [DATA_W-1:0]    ReadData_o;
  logic                 RF_WE_o;
  logic                 MemWE_o;
  logic                 WBSelect_o;
  logic [DATA_W-1:0]    AluResult_o;
  logic [REG_IDX_W-1:0] A3_o;

  modport master (
    output RD2_i, RF_WE_i, MemWE_i, WBSelect_i, AluResult_i, A3_i,
    input  AluResult_mem_o, A3_mem_o, RF_WE_mem_o,
    input  ReadData_o, RF_WE_o, MemWE_o, WBSelect_o, AluResult_o, A3_o
  );

  modport slave (
    input  RD2_i, RF_WE_i, MemWE_i, WBSelect_i, AluResult_i, A3_i,
    output AluResult_mem_o, A3_mem_o, RF_WE_mem_o,
    output ReadData_o, RF_WE_o, MemWE_o, WBSelect_o, AluResult_o, A3_o
  );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register with synchronous active-high clear.
module pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  always_comb begin
    q_d = rst_i ? '0 : d_i;
  end

  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: EX/MEM register, word data memory, MEM/WB register.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic      CLK,
  input  logic      RST,
  stage_mem_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;

  logic [ADDR_W-1:0] mem_idx;
  logic [DATA_W-1:0] read_data;
  logic              mem_we;

  // Zero at configuration; deliberately never cleared by RST.
  logic [DATA_W-1:0] mem_q [Depth] = '{default: '0};

  always_comb begin
    ex_mem_d                = '0;
    ex_mem_d.rd2            = bus.RD2_i;
    ex_mem_d.ctrl.rf_we     = bus.RF_WE_i;
    ex_mem_d.ctrl.mem_we    = bus.MemWE_i;
    ex_mem_d.ctrl.wb_select = bus.WBSelect_i;
    ex_mem_d.alu_result     = bus.AluResult_i;
    ex_mem_d.a3             = bus.A3_i;
  end

  pipe_reg #(
    .Width($bits(ex_mem_t))
  ) u_ex_mem (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (ex_mem_d),
    .q_o  (ex_mem_q)
  );

  // Upper address bits are dropped so addresses alias modulo the depth.
  assign mem_idx = ex_mem_q.alu_result[ADDR_W-1:0];

  // Asynchronous read returns pre-write contents on a same-cycle store.
  assign read_data = mem_q[mem_idx];
  assign mem_we    = ex_mem_q.ctrl.mem_we && !RST;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_idx] <= ex_mem_q.rd2;
    end
  end

  always_comb begin
    mem_wb_d            = '0;
    mem_wb_d.read_data  = read_data;
    mem_wb_d.ctrl       = ex_mem_q.ctrl;
    mem_wb_d.alu_result = ex_mem_q.alu_result;
    mem_wb_d.a3         = ex_mem_q.a3;
  end

  pipe_reg #(
    .Width($bits(mem_wb_t))
  ) u_mem_wb (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (mem_wb_d),
    .q_o  (mem_wb_q)
  );

  assign bus.AluResult_mem_o = ex_mem_q.alu_result;
  assign bus.A3_mem_o        = ex_mem_q.a3;
  assign bus.RF_WE_mem_o     = ex_mem_q.ctrl.rf_we;

  assign bus.ReadData_o  = mem_wb_q.read_data;
  assign bus.RF_WE_o     = mem_wb_q.ctrl.rf_we;
  assign bus.MemWE_o     = mem_wb_q.ctrl.mem_we;
  assign bus.WBSelect_o  = mem_wb_q.ctrl.wb_select;
  assign bus.AluResult_o = mem_wb_q.alu_result;
  assign bus.A3_o        = mem_wb_q.a3;

endmodule

// File: tb/tb_stage_mem.sv
// Directed-vector bench for stage_mem with hand-computed expectations.
module tb_stage_mem;
  import stage_mem_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  stage_mem_if sm_if ();

  stage_mem #(
    .ADDR_W(10)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(sm_if)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] data, input logic we,
                       input logic rfwe, input logic wbsel, input logic [3:0] a3);
    sm_if.AluResult_i = addr;
    sm_if.RD2_i       = data;
    sm_if.MemWE_i     = we;
    sm_if.RF_WE_i     = rfwe;
    sm_if.WBSelect_i  = wbsel;
    sm_if.A3_i        = a3;
  endtask

  function automatic logic [107:0] all_outputs();
    return {sm_if.AluResult_mem_o, sm_if.A3_mem_o, sm_if.RF_WE_mem_o, sm_if.ReadData_o,
            sm_if.RF_WE_o, sm_if.MemWE_o, sm_if.WBSelect_o, sm_if.AluResult_o, sm_if.A3_o};
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    drive(32'h1234_5678, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1, 4'hF);
    tick();
    tick();
    n_cmp++;
    if (all_outputs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", all_outputs());
    end
    RST = 1'b0;
  endtask

  task automatic test_fill();
    for (int n = 0; n < 100; n++) begin
      drive(n, n, 1'b1, 1'b0, 1'b0, 4'h0);
      tick();
      if (n > 0) begin
        n_cmp++;
        if (sm_if.AluResult_o !== 32'(n - 1) || sm_if.MemWE_o !== 1'b1) begin
          n_fail++;
          $display("FAIL fill_wb[%0d]: got alu=%0d we=%b want alu=%0d we=1", n - 1,
                   sm_if.AluResult_o, sm_if.MemWE_o, n - 1);
        end
      end
    end
  endtask

  task automatic test_readback();
    logic [31:0] exp;
    for (int n = 0; n <= 101; n++) begin
      if (n <= 100) drive(n, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      else          drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      tick();
      if (n >= 1) begin
        exp = (n - 1 < 100) ? 32'(n - 1) : 32'h0;
        n_cmp++;
        if (sm_if.ReadData_o !== exp) begin
          n_fail++;
          $display("FAIL readback[%0d]: got %h want %h", n - 1, sm_if.ReadData_o, exp);
        end
      end
    end
  endtask

  task automatic test_alias();
    drive(32'd1024, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 4'h0);
    tick();
    drive(32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    n_cmp++;
    if (sm_if.ReadData_o !== 32'h0) begin
      n_fail++;
      $display("FAIL alias_store_read: got %h want 00000000", sm_if.ReadData_o);
    end
    drive(32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    n_cmp++;
    if (sm_if.ReadData_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL alias_load0: got %h want deadbeef", sm_if.ReadData_o);
    end
  endtask

  task automatic test_back_to_back_rdw();
    drive(32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 4'h0);
    tick();
    drive(32'd5, 32'd9, 1'b1, 1'b0, 1'b0, 4'h0);
    tick();
    n_cmp++;
    if (sm_if.ReadData_o !== 32'd5) begin
      n_fail++;
      $display("FAIL rdw_first_store: got %0d want 5", sm_if.ReadData_o);
    end
    drive(32'd5, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    n_cmp++;
    if (sm_if.ReadData_o !== 32'd7) begin
      n_fail++;
      $display("FAIL rdw_old_value: got %0d want 7", sm_if.ReadData_o);
    end
    drive(32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    n_cmp++;
    if (sm_if.ReadData_o !== 32'd9) begin
      n_fail++;
      $display("FAIL rdw_new_value: got %0d want 9", sm_if.ReadData_o);
    end
  endtask

  task automatic test_reset_mid();
    drive(32'd3, 32'h0000_0333, 1'b1, 1'b1, 1'b1, 4'h7);
    tick();
    RST = 1'b1;
    drive(32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    n_cmp++;
    if (all_outputs() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h want 0", all_outputs());
    end
    RST = 1'b0;
    drive(32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    drive(32'd2, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    n_cmp++;
    if (sm_if.ReadData_o !== 32'd3) begin
      n_fail++;
      $display("FAIL reset_mid_mem3: got %h want 00000003", sm_if.ReadData_o);
    end
    drive(32'd5, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    n_cmp++;
    if (sm_if.ReadData_o !== 32'd2) begin
      n_fail++;
      $display("FAIL reset_mid_mem2: got %h want 00000002", sm_if.ReadData_o);
    end
    drive(32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    n_cmp++;
    if (sm_if.ReadData_o !== 32'd9) begin
      n_fail++;
      $display("FAIL reset_mid_mem5: got %h want 00000009", sm_if.ReadData_o);
    end
  endtask

  task automatic test_passthrough();
    drive(32'h55, 32'h0, 1'b0, 1'b1, 1'b1, 4'hA);
    tick();
    n_cmp++;
    if (sm_if.A3_mem_o !== 4'hA || sm_if.RF_WE_mem_o !== 1'b1 ||
        sm_if.AluResult_mem_o !== 32'h55) begin
      n_fail++;
      $display("FAIL pass_mem: got a3=%h rfwe=%b alu=%h want a3=a rfwe=1 alu=55",
               sm_if.A3_mem_o, sm_if.RF_WE_mem_o, sm_if.AluResult_mem_o);
    end
    n_cmp++;
    if (sm_if.A3_o === 4'hA) begin
      n_fail++;
      $display("FAIL pass_early: got a3_o=%h want not a before second edge", sm_if.A3_o);
    end
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    n_cmp++;
    if (sm_if.A3_o !== 4'hA || sm_if.RF_WE_o !== 1'b1 || sm_if.WBSelect_o !== 1'b1 ||
        sm_if.MemWE_o !== 1'b0 || sm_if.AluResult_o !== 32'h55) begin
      n_fail++;
      $display("FAIL pass_wb: got a3=%h rfwe=%b wbsel=%b we=%b alu=%h want a3=a rfwe=1 wbsel=1 we=0 alu=55",
               sm_if.A3_o, sm_if.RF_WE_o, sm_if.WBSelect_o, sm_if.MemWE_o, sm_if.AluResult_o);
    end
    n_cmp++;
    if (sm_if.A3_mem_o !== 4'h0 || sm_if.RF_WE_mem_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_mem_next: got a3=%h rfwe=%b want a3=0 rfwe=0",
               sm_if.A3_mem_o, sm_if.RF_WE_mem_o);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_readback();
    test_alias();
    test_back_to_back_rdw();
    test_reset_mid();
    test_passthrough();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
